d_stream_serializer: RTL and testbench

//  Parallel-in/serial-out transmitter feeding a chain of enable-gated D flops.

---
 rtl/d_stream_serializer_pkg.sv | 18 +
 rtl/d_stream_bit_timer.sv | 33 +++
 rtl/d_stream_serializer.sv | 109 ++++++++++
 tb/tb_d_stream_serializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/d_stream_serializer_pkg.sv
// Shared definitions for the D/E stream serializer: FSM encodings, idle line level
// and counter-width helper.
package d_stream_serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width that can hold the terminal count n without wrapping, plus headroom.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/d_stream_bit_timer.sv
// DIV-cycle bit timer: counts clocks while enabled and pulses tick on the last
// cycle of each serial bit. Synchronous active-low reset.
module d_stream_bit_timer
  import d_stream_serializer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/d_stream_serializer.sv
// Parallel-in/serial-out D/E producer: MSB-first, each bit held DIV clocks with a
// one-cycle E_OUT strobe. Optional even parity bit via macro D_STREAM_PARITY_EN.
module d_stream_serializer
  import d_stream_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             D_OUT,
  output logic             E_OUT,
  output logic             BUSY,
  output logic             DONE
);

`ifdef D_STREAM_PARITY_EN
  localparam int NUM_BITS = WIDTH + 1;
`else
  localparam int NUM_BITS = WIDTH;
`endif

  localparam int BW = cnt_width(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH:0]   shreg_shifted;
  logic [BW-1:0]    bit_cnt;
  logic             tick;
  logic             accept;
  logic             in_shift;
  logic             fill;

  assign in_shift   = (state == S_SHIFT);
  assign LOAD_READY = RST && (state == S_IDLE);
  assign accept     = LOAD_READY && LOAD_VALID;

  d_stream_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk    (CLK),
    .rst_n  (RST),
    .clear  (!in_shift),
    .enable (in_shift),
    .tick   (tick)
  );

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_SHIFT;
      S_SHIFT: if (tick && (bit_cnt == LAST_BIT)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        bit_cnt <= '0;
      end else if (in_shift && tick) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef D_STREAM_PARITY_EN
  // Parity enters at the LSB on every shift; after WIDTH shifts it reaches the MSB.
  logic parity;

  always_ff @(posedge CLK) begin
    if (accept) begin
      parity <= ^LOAD_DATA;
    end
  end

  assign fill = parity;
`else
  assign fill = IDLE_LEVEL;
`endif

  assign shreg_shifted = {shreg, fill};

  // NOTE: the datapath register has no reset; D_OUT is forced to the idle level outside SHIFT.
  always_ff @(posedge CLK) begin
    if (accept) begin
      shreg <= LOAD_DATA;
    end else if (in_shift && tick) begin
      shreg <= shreg_shifted[WIDTH-1:0];
    end
  end

  assign D_OUT = in_shift ? shreg[WIDTH-1] : IDLE_LEVEL;
  assign E_OUT = tick;
  assign BUSY  = in_shift;
  assign DONE  = (state == S_DONE);

endmodule

// File: tb/tb_d_stream_serializer.sv
// Self-checking bench for d_stream_serializer: directed steps, expected bits queued
// on accept and compared on each E_OUT strobe. Two instances: DIV=4 and DIV=1.
`timescale 1ns/1ps
module tb_d_stream_serializer;

  localparam int WIDTH = 8;
  localparam int DIV_A = 4;
  localparam int DIV_B = 1;
`ifdef D_STREAM_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int DONE_A = NB * DIV_A + 1;
  localparam int DONE_B = NB * DIV_B + 1;
  localparam int BUDGET = 400;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] data_a = '0, data_b = '0;
  logic             valid_a = 1'b0, valid_b = 1'b0;
  logic             ready_a, d_a, e_a, busy_a, done_a;
  logic             ready_b, d_b, e_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  bit q_a[$];
  bit q_b[$];

  always #5 clk = ~clk;

  d_stream_serializer #(.WIDTH(WIDTH), .DIV(DIV_A)) dut_a (
    .CLK(clk), .RST(rst), .LOAD_DATA(data_a), .LOAD_VALID(valid_a),
    .LOAD_READY(ready_a), .D_OUT(d_a), .E_OUT(e_a), .BUSY(busy_a), .DONE(done_a)
  );

  d_stream_serializer #(.WIDTH(WIDTH), .DIV(DIV_B)) dut_b (
    .CLK(clk), .RST(rst), .LOAD_DATA(data_b), .LOAD_VALID(valid_b),
    .LOAD_READY(ready_b), .D_OUT(d_b), .E_OUT(e_b), .BUSY(busy_b), .DONE(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w, input bit to_b);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (to_b) q_b.push_back(w[i]);
      else      q_a.push_back(w[i]);
    end
`ifdef D_STREAM_PARITY_EN
    if (to_b) q_b.push_back(^w);
    else      q_a.push_back(^w);
`endif
  endtask

  task automatic pop_a(input string tag, input logic obs);
    if (q_a.size() == 0) check({tag, "_underflow"}, 32'd0, 32'd1);
    else check(tag, obs, q_a.pop_front());
  endtask

  task automatic pop_b(input string tag, input logic obs);
    if (q_b.size() == 0) check({tag, "_underflow"}, 32'd0, 32'd1);
    else check(tag, obs, q_b.pop_front());
  endtask

  task automatic wait_ready_a();
    int n = 0;
    while (!ready_a && n < 50) begin
      tick();
      n++;
    end
    check("a_ready_wait", ready_a, 1'b1);
  endtask

  // Transmit one word on instance A and track strobes/bits/DONE against the scoreboard.
  task automatic send_a(input logic [WIDTH-1:0] w, input bit toggle);
    int cyc = 1;
    int strobes = 0;
    bit done_seen = 0;
    wait_ready_a();
    data_a  = w;
    valid_a = 1'b1;
    push_word(w, 1'b0);
    tick();
    valid_a = 1'b0;
    while (cyc <= BUDGET && !done_seen) begin
      if (toggle && busy_a) begin
        check("a_ready_in_shift", ready_a, 1'b0);
        if (cyc % 3 == 0) begin
          valid_a = ~valid_a;
          data_a  = 8'h3C;
        end
      end
      if (e_a) begin
        strobes++;
        check("a_strobe_cycle", cyc, strobes * DIV_A);
        pop_a("a_bit", d_a);
      end
      if (done_a) begin
        valid_a   = 1'b0;
        done_seen = 1;
        check("a_done_cycle", cyc, DONE_A);
        check("a_idle_level_at_done", d_a, 1'b1);
      end
      tick();
      cyc++;
    end
    if (!done_seen) check("a_done_timeout", 32'd0, 32'd1);
    check("a_strobe_count", strobes, NB);
    check("a_sb_empty", q_a.size(), 0);
  endtask

  initial begin
    int cyc;
    int first_done;
    bit accepted2;
    bit drop_valid;
    bit finished;

    // Power-on reset, three edges low.
    rst = 1'b0;
    repeat (3) tick();
    check("rst_d_out", d_a, 1'b1);
    check("rst_e_out", e_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_ready_low", ready_a, 1'b0);
    rst = 1'b1;
    tick();
    check("rst_ready_after_release", ready_a, 1'b1);

    // Basic word.
    send_a(8'hA5, 1'b0);

    // LOAD_VALID toggled with 8'h3C during SHIFT must be ignored.
    send_a(8'h66, 1'b1);
    tick();
    check("a_ready_after_toggle", ready_a, 1'b1);

    // Reset mid-transfer after three bits of 8'hC3.
    wait_ready_a();
    data_a  = 8'hC3;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    repeat (3 * DIV_A) tick();
    check("abort_busy_before", busy_a, 1'b1);
    check("abort_bit3", d_a, 1'b0);
    rst = 1'b0;
    check("abort_ready_comb", ready_a, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_d_out", d_a, 1'b1);
      check("abort_e_out", e_a, 1'b0);
      check("abort_busy", busy_a, 1'b0);
      check("abort_done", done_a, 1'b0);
      check("abort_ready", ready_a, 1'b0);
    end
    rst = 1'b1;
    tick();
    check("abort_ready_release", ready_a, 1'b1);
    check("abort_no_done", done_a, 1'b0);
    send_a(8'h81, 1'b0);

    // DIV=1 back-to-back: 8'hFF then 8'h00 held valid through SHIFT.
    data_b  = 8'hFF;
    valid_b = 1'b1;
    check("b_ready_start", ready_b, 1'b1);
    push_word(8'hFF, 1'b1);
    tick();
    data_b     = 8'h00;
    cyc        = 1;
    first_done = 0;
    accepted2  = 0;
    drop_valid = 0;
    finished   = 0;
    while (cyc <= BUDGET && !finished) begin
      if (busy_b) begin
        check("b_e_every_shift", e_b, 1'b1);
        pop_b("b_bit", d_b);
      end else begin
        check("b_e_idle", e_b, 1'b0);
      end
      if (done_b) begin
        if (first_done == 0) begin
          first_done = cyc;
          check("b_first_done_cycle", cyc, DONE_B);
        end else begin
          check("b_second_done_cycle", cyc, first_done + 1 + NB + 1);
          finished = 1;
        end
      end
      if (ready_b && valid_b && !accepted2 && first_done != 0) begin
        check("b_accept_gap", cyc, first_done + 1);
        accepted2  = 1;
        drop_valid = 1;
        push_word(8'h00, 1'b1);
      end
      tick();
      cyc++;
      if (drop_valid) begin
        valid_b    = 1'b0;
        drop_valid = 0;
        check("b_second_busy", busy_b, 1'b1);
      end
    end
    if (!finished) check("b_done_timeout", 32'd0, 32'd1);
    check("b_sb_empty", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
